// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU result checker: op codes, FSM states and
// the reference function that turns {A, B, op} into the expected result.
package alu_chk_pkg;

  // Widest operand the reference function handles; narrower DATA_W truncates.
  localparam int unsigned CHK_W = 64;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {illegal, value}; unsupported codes expect zero.
  function automatic logic [CHK_W:0] alu_expect(input logic [CHK_W-1:0] a,
                                                input logic [CHK_W-1:0] b,
                                                input logic [3:0]       op);
    logic [CHK_W:0] r;
    r = '0;
    case (op)
      OP_AND:   r[CHK_W-1:0] = a & b;
      OP_ORR:   r[CHK_W-1:0] = a | b;
      OP_ADD:   r[CHK_W-1:0] = a + b;
      OP_SUB:   r[CHK_W-1:0] = a - b;
      OP_PASSB: r[CHK_W-1:0] = b;
      OP_NOR:   r[CHK_W-1:0] = ~(a | b);
      default:  r[CHK_W]     = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO holding expected-result entries; extra pointer bit
// distinguishes full from empty. clear empties it in one cycle.
module chk_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_result_checker.sv
// Queues expected ALU results, compares returning results in order and
// reports counts and a verdict. CHECKER_ZERO_FLAG_EN also checks res_zero.
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_VEC = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           stim_valid,
  output logic                           stim_ready,
  input  logic [DATA_W-1:0]              a_in,
  input  logic [DATA_W-1:0]              b_in,
  input  logic [3:0]                     op_in,
  input  logic                           res_valid,
  input  logic [DATA_W-1:0]              res_in,
  input  logic                           res_zero,
  output logic [$clog2(NUM_VEC+1)-1:0]   pass_cnt,
  output logic [$clog2(NUM_VEC+1)-1:0]   fail_cnt,
  output logic                           orphan,
  output logic                           illegal_op,
  output logic [$clog2(NUM_VEC)-1:0]     first_fail_idx,
  output logic                           done,
  output logic                           all_pass
);

  localparam int unsigned CNT_W = $clog2(NUM_VEC+1);
  localparam int unsigned IDX_W = $clog2(NUM_VEC);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
`ifdef CHECKER_ZERO_FLAG_EN
    logic              zero;
`endif
    logic [DATA_W-1:0] value;
  } entry_t;

  state_t             state;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   push_idx_nxt;
  logic [CHK_W-1:0]   a_ext;
  logic [CHK_W-1:0]   b_ext;
  logic [CHK_W:0]     exp_full;
  entry_t             push_entry;
  entry_t             head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               orphan_hit;
  logic               match;
  logic [CNT_W-1:0]   pass_nxt;
  logic [CNT_W-1:0]   fail_nxt;
  logic               orphan_nxt;
  logic               illegal_nxt;
  logic               run_over;

  assign stim_ready = (state == RUN) & ~full;
  // A start pulse clears the queue, so traffic in that cycle is dropped.
  assign push       = stim_valid & stim_ready & ~start;
  assign pop        = res_valid & (state == RUN) & ~empty & ~start;
  assign orphan_hit = res_valid & (state == RUN) & empty & ~start;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[DATA_W-1:0] = a_in;
    b_ext[DATA_W-1:0] = b_in;
    exp_full = alu_expect(a_ext, b_ext, op_in);
    push_entry = '0;
    push_entry.idx   = push_idx;
    push_entry.value = exp_full[DATA_W-1:0];
`ifdef CHECKER_ZERO_FLAG_EN
    push_entry.zero  = (exp_full[DATA_W-1:0] == '0);
`endif
  end

`ifdef CHECKER_ZERO_FLAG_EN
  assign match = (res_in == head.value) && (res_zero == head.zero);
`else
  logic unused_res_zero;
  assign unused_res_zero = res_zero;
  assign match = (res_in == head.value);
`endif

  always_comb begin
    pass_nxt     = pass_cnt + CNT_W'(pop & match);
    fail_nxt     = fail_cnt + CNT_W'(pop & ~match);
    orphan_nxt   = orphan | orphan_hit;
    illegal_nxt  = illegal_op | (push & exp_full[CHK_W]);
    run_over     = (({1'b0, pass_nxt} + {1'b0, fail_nxt}) == (CNT_W+1)'(NUM_VEC));
    push_idx_nxt = (push_idx == IDX_W'(NUM_VEC - 1)) ? '0 : push_idx + IDX_W'(1);
  end

  chk_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start),
    .push    (push),
    .pop     (pop),
    .din     (push_entry),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  // Reset and start share the clearing path; only the next state differs.
  always_ff @(posedge clock) begin
    if (!reset_n || start) begin
      state          <= reset_n ? RUN : IDLE;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      orphan         <= 1'b0;
      illegal_op     <= 1'b0;
      first_fail_idx <= '0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
      push_idx       <= '0;
    end else if (state == RUN) begin
      pass_cnt   <= pass_nxt;
      fail_cnt   <= fail_nxt;
      orphan     <= orphan_nxt;
      illegal_op <= illegal_nxt;
      if (push) push_idx <= push_idx_nxt;
      if (pop && !match && fail_cnt == '0) first_fail_idx <= head.idx;
      if (run_over) begin
        state    <= DONE;
        done     <= 1'b1;
        all_pass <= (fail_nxt == '0) & ~orphan_nxt & ~illegal_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random runs.
module tb_alu_result_checker;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NUM_VEC = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stim_valid = 1'b0;
  logic        stim_ready;
  logic [63:0] a_in = '0;
  logic [63:0] b_in = '0;
  logic [3:0]  op_in = '0;
  logic        res_valid = 1'b0;
  logic [63:0] res_in = '0;
  logic        res_zero = 1'b0;
  logic [3:0]  pass_cnt;
  logic [3:0]  fail_cnt;
  logic        orphan;
  logic        illegal_op;
  logic [2:0]  first_fail_idx;
  logic        done;
  logic        all_pass;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_result_checker #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .NUM_VEC (NUM_VEC)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .stim_valid     (stim_valid),
    .stim_ready     (stim_ready),
    .a_in           (a_in),
    .b_in           (b_in),
    .op_in          (op_in),
    .res_valid      (res_valid),
    .res_in         (res_in),
    .res_zero       (res_zero),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .orphan         (orphan),
    .illegal_op     (illegal_op),
    .first_fail_idx (first_fail_idx),
    .done           (done),
    .all_pass       (all_pass)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned idx;
    logic [63:0] exp;
  } ent_t;

  ent_t        mq[$];
  bit          m_run, m_done, m_orphan, m_illegal, m_all_pass;
  int unsigned m_pass, m_fail, m_ffi, m_idx;
  bit          model_live = 0;

  function automatic logic [64:0] ref_expect(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] op);
    case (op)
      4'd0:    return {1'b0, a & b};
      4'd1:    return {1'b0, a | b};
      4'd2:    return {1'b0, a + b};
      4'd6:    return {1'b0, a - b};
      4'd7:    return {1'b0, b};
      4'd12:   return {1'b0, ~(a | b)};
      default: return {1'b1, 64'h0};
    endcase
  endfunction

  task automatic model_clear();
    m_done = 0; m_orphan = 0; m_illegal = 0; m_all_pass = 0;
    m_pass = 0; m_fail = 0; m_ffi = 0; m_idx = 0;
    mq.delete();
  endtask

  always @(posedge clock) begin
    bit          can_push;
    ent_t        h;
    logic [64:0] e;
    if (!reset_n) begin
      m_run = 0;
      model_clear();
      model_live = 1;
    end else if (start) begin
      m_run = 1;
      model_clear();
    end else if (m_run) begin
      can_push = (mq.size() < DEPTH);
      if (res_valid) begin
        if (mq.size() == 0) m_orphan = 1;
        else begin
          h = mq.pop_front();
          if (h.exp == res_in) m_pass++;
          else begin
            if (m_fail == 0) m_ffi = h.idx;
            m_fail++;
          end
        end
      end
      if (stim_valid && can_push) begin
        e = ref_expect(a_in, b_in, op_in);
        if (e[64]) m_illegal = 1;
        mq.push_back('{idx: m_idx, exp: e[63:0]});
        m_idx = (m_idx + 1) % NUM_VEC;
      end
      if (m_pass + m_fail == NUM_VEC) begin
        m_run = 0;
        m_done = 1;
        m_all_pass = (m_fail == 0) && !m_orphan && !m_illegal;
      end
    end
  end

  task automatic cmp(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_live) begin
      cmp("stim_ready", 65'(stim_ready), 65'(m_run && mq.size() < DEPTH));
      cmp("pass_cnt", 65'(pass_cnt), 65'(m_pass));
      cmp("fail_cnt", 65'(fail_cnt), 65'(m_fail));
      cmp("orphan", 65'(orphan), 65'(m_orphan));
      cmp("illegal_op", 65'(illegal_op), 65'(m_illegal));
      cmp("first_fail_idx", 65'(first_fail_idx), 65'(m_ffi));
      cmp("done", 65'(done), 65'(m_done));
      cmp("all_pass", 65'(all_pass), 65'(m_all_pass));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    stim_valid = 1; a_in = a; b_in = b; op_in = op;
    tick();
    stim_valid = 0;
  endtask

  task automatic result(input logic [63:0] r);
    res_valid = 1; res_in = r; res_zero = (r == 0);
    tick();
    res_valid = 0;
  endtask

  logic [63:0] va [8];
  logic [63:0] vb [8];
  logic [3:0]  vop [8];

  initial begin
    // reset values
    tick(); tick();
    cmp("rst_stim_ready", 65'(stim_ready), 65'd0);
    cmp("rst_pass", 65'(pass_cnt), 65'd0);
    cmp("rst_fail", 65'(fail_cnt), 65'd0);
    cmp("rst_orphan", 65'(orphan), 65'd0);
    cmp("rst_illegal", 65'(illegal_op), 65'd0);
    cmp("rst_ffi", 65'(first_fail_idx), 65'd0);
    cmp("rst_done", 65'(done), 65'd0);
    cmp("rst_all_pass", 65'(all_pass), 65'd0);
    reset_n = 1;
    tick();

    // results in IDLE are ignored
    result(64'd5);
    cmp("idle_orphan", 65'(orphan), 65'd0);

    // pin the model
    cmp("model_sub", ref_expect(64'd3, 64'd5, 4'd6), {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    cmp("model_add_wrap", ref_expect(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd2), 65'd0);
    cmp("model_illegal", ref_expect(64'd7, 64'd7, 4'hF), {1'b1, 64'h0});

    // ADD 5+7
    do_start();
    cmp("start_ready", 65'(stim_ready), 65'd1);
    push(64'd5, 64'd7, 4'd2);
    result(64'd12);
    cmp("add_pass", 65'(pass_cnt), 65'd1);
    cmp("add_fail", 65'(fail_cnt), 65'd0);

    // SUB 3-5: wrong then right
    do_start();
    push(64'd3, 64'd5, 4'd6);
    result(64'h2);
    cmp("sub_fail", 65'(fail_cnt), 65'd1);
    cmp("sub_ffi", 65'(first_fail_idx), 65'd0);
    push(64'd3, 64'd5, 4'd6);
    result(64'hFFFF_FFFF_FFFF_FFFE);
    cmp("sub_pass", 65'(pass_cnt), 65'd1);

    // full queue, refused push, simultaneous push/pop, orphan
    do_start();
    push(64'hF0F0, 64'hFF00, 4'd0);
    push(64'h0F, 64'hF0, 4'd1);
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd2);
    push(64'd1, 64'h1234, 4'd7);
    cmp("full_ready", 65'(stim_ready), 65'd0);
    push(64'd9, 64'd9, 4'd2);
    result(64'hF000);
    cmp("pop_ready", 65'(stim_ready), 65'd1);
    stim_valid = 1; a_in = 64'd10; b_in = 64'd3; op_in = 4'd6;
    res_valid = 1; res_in = 64'hFF;
    tick();
    stim_valid = 0; res_valid = 0;
    cmp("pushpop_ready", 65'(stim_ready), 65'd1);
    push(64'd0, 64'd0, 4'd12);
    cmp("refull_ready", 65'(stim_ready), 65'd0);
    result(64'd0);
    result(64'h1234);
    result(64'd7);
    result(64'hFFFF_FFFF_FFFF_FFFF);
    cmp("drain_pass", 65'(pass_cnt), 65'd6);
    cmp("drain_fail", 65'(fail_cnt), 65'd0);
    result(64'd0);
    cmp("orphan_set", 65'(orphan), 65'd1);
    cmp("orphan_pass", 65'(pass_cnt), 65'd6);
    push(64'd1, 64'd1, 4'd2);
    result(64'd2);
    push(64'd2, 64'd2, 4'd2);
    result(64'd4);
    cmp("orphan_done", 65'(done), 65'd1);
    cmp("orphan_all_pass", 65'(all_pass), 65'd0);

    // full run with one illegal op
    vop[0] = 4'd0; vop[1] = 4'd1; vop[2] = 4'd2; vop[3] = 4'd6;
    vop[4] = 4'd7; vop[5] = 4'd12; vop[6] = 4'd2; vop[7] = 4'hF;
    cmp("model_and", ref_expect(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 4'd0), 65'd0);
    cmp("model_nor", ref_expect(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 4'd12), 65'd0);
    do_start();
    for (int i = 0; i < 8; i++) begin
      logic [64:0] e;
      e = ref_expect(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, vop[i]);
      push(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, vop[i]);
      result(e[63:0]);
    end
    cmp("run_illegal", 65'(illegal_op), 65'd1);
    cmp("run_pass", 65'(pass_cnt), 65'd8);
    cmp("run_done", 65'(done), 65'd1);
    cmp("run_all_pass", 65'(all_pass), 65'd0);

    // reset mid-run, then a clean run
    do_start();
    push(64'd1, 64'd2, 4'd2);
    push(64'd3, 64'd4, 4'd2);
    reset_n = 0; tick(); reset_n = 1;
    cmp("mid_rst_ready", 65'(stim_ready), 65'd0);
    cmp("mid_rst_pass", 65'(pass_cnt), 65'd0);
    cmp("mid_rst_done", 65'(done), 65'd0);
    do_start();
    for (int i = 0; i < 8; i++) begin
      push(64'(i), 64'(i + 1), 4'd2);
      result(64'(2 * i + 1));
    end
    cmp("clean_done", 65'(done), 65'd1);
    cmp("clean_all_pass", 65'(all_pass), 65'd1);
    cmp("clean_fail", 65'(fail_cnt), 65'd0);

    // randomized runs
    for (int run = 0; run < 12; run++) begin
      bit clean;
      int cyc;
      clean = (run % 3 == 0);
      do_start();
      cyc = 0;
      while (!m_done && cyc < 300) begin
        logic [3:0] ops [6];
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2;
        ops[3] = 4'd6; ops[4] = 4'd7; ops[5] = 4'd12;
        stim_valid = ($urandom % 2) == 1;
        a_in = ($urandom % 4 == 0) ? 64'($urandom % 8) : {$urandom, $urandom};
        b_in = ($urandom % 4 == 0) ? 64'($urandom % 8) : {$urandom, $urandom};
        op_in = (!clean && $urandom % 10 == 0) ? 4'($urandom_range(0, 15))
                                               : ops[$urandom % 6];
        if (mq.size() > 0) begin
          res_valid = ($urandom % 3) != 0;
          res_in = mq[0].exp;
          if (!clean && $urandom % 8 == 0) res_in = res_in ^ (64'd1 << ($urandom % 64));
        end else begin
          res_valid = !clean && ($urandom % 16 == 0);
          res_in = {$urandom, $urandom};
        end
        res_zero = (res_in == 0);
        if (!clean && $urandom % 150 == 0) begin
          stim_valid = 0; res_valid = 0; start = 1;
        end
        tick();
        start = 0;
        cyc++;
      end
      stim_valid = 0; res_valid = 0;
      tick();
      cmp("rand_run_done", 65'(done), 65'd1);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
